quant_wr_sched: RTL and testbench

- Scheduler/arbiter at the input of the quantization pipeline.
- Shares the single quantization write path between NREQ requesters using round-robin arbitration. Typical requesters: the PE-array psum writeback and the DMA/host debug write.
- Quantization has a fixed 6-cycle latency and cannot stall. This block therefore admits a write only when a downstream credit is available. Credits represent free slots in the output SRAM write FIFO.
- Also provides a flush sequence that drains all in-flight writes before a layer switch.

---
 rtl/quant_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/quant_wr_sched.sv | 199 +++++++++++++++++++
 tb/tb_quant_wr_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/quant_sched_pkg.sv
// Shared types and constants for the quantization write scheduler.
package quant_sched_pkg;

  localparam int QS_SRAMC_W = 1024;
  localparam int QS_ADRC_W  = 11;
  localparam int QS_SRAMC_N = 32;
  localparam int QUANT_LAT  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [QS_SRAMC_W-1:0] wdata;
    logic [QS_ADRC_W-1:0]  addr;
    logic [QS_SRAMC_N-1:0] wmask;
  } q_req_t;

  // Pointer width that stays legal for a single-requester configuration.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first active request
// found after i_ptr, only while i_advance is high.
module rr_arbiter
  import quant_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = ptr_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic            i_advance,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic          w_found;
  logic          w_hit;
  logic [PW-1:0] w_idx;

  // Walk the requesters starting one past the last winner.
  always_comb begin
    o_grant = {NREQ{1'b0}};
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_idx   = {PW{1'b0}};
    for (int off = 1; off <= NREQ; off++) begin
      w_idx          = PW'((int'(i_ptr) + off) % NREQ);
      w_hit          = i_advance & ~w_found & i_req[w_idx];
      o_grant[w_idx] = w_hit;
      w_found        = w_found | w_hit;
    end
  end

endmodule

// File: rtl/quant_wr_sched.sv
// Credit-gated round-robin scheduler feeding the fixed-latency quantization
// write path, with a flush sequence that drains in-flight writes.
module quant_wr_sched
  import quant_sched_pkg::*;
#(
  parameter int SRAMC_W = QS_SRAMC_W,
  parameter int ADRC_W  = QS_ADRC_W,
  parameter int SRAMC_N = QS_SRAMC_N,
  parameter int NREQ    = 2,
  parameter int CREDITS = 8,
  parameter int CRD_W   = $clog2(CREDITS + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*SRAMC_W-1:0] i_req_wdata,
  input  logic [NREQ*ADRC_W-1:0]  i_req_addr,
  input  logic [NREQ*SRAMC_N-1:0] i_req_wmask,
  output logic [SRAMC_W-1:0]      o_q_wdata,
  output logic [ADRC_W-1:0]       o_q_addr,
  output logic [0:SRAMC_N-1]      o_q_wmask,
  output logic                    o_q_wren,
  input  logic                    i_credit_ret,
  input  logic                    i_flush,
  output logic                    o_flush_done,
  output logic                    o_busy,
  output logic [CRD_W-1:0]        o_credits,
  output logic                    o_err
);

  localparam int               PW       = ptr_w(NREQ);
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDITS);

  sched_state_e       r_state;
  sched_state_e       w_state_nxt;
  logic [CRD_W-1:0]   r_credits;
  logic [CRD_W-1:0]   w_credits_nxt;
  logic               r_err;
  logic               w_crd_ovf;
  logic [PW-1:0]      r_rr_ptr;
  logic [PW-1:0]      w_gnt_idx;
  logic [NREQ-1:0]    w_grant;
  logic               w_gnt_en;
  logic               w_accept;
  logic               w_any_valid;
  logic               w_crd_full;
  logic [SRAMC_W-1:0] w_sel_wdata;
  logic [ADRC_W-1:0]  w_sel_addr;
  logic [SRAMC_N-1:0] w_sel_wmask;
  logic [SRAMC_W-1:0] r_q_wdata;
  logic [ADRC_W-1:0]  r_q_addr;
  logic [0:SRAMC_N-1] r_q_wmask;
  logic               r_q_wren;

  assign w_any_valid = |i_req_valid;
  assign w_crd_full  = (r_credits == CRD_FULL);
  // Held low during reset so ready shows its reset value even with valid high.
  assign w_gnt_en    = i_rstn && (r_state != FLUSH) && (r_credits != {CRD_W{1'b0}}) && !i_flush;
  assign w_accept    = |w_grant;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .i_req     (i_req_valid),
    .i_advance (w_gnt_en),
    .i_ptr     (r_rr_ptr),
    .o_grant   (w_grant)
  );

  // Winner index and AND-OR payload mux from the one-hot grant.
  always_comb begin
    w_gnt_idx   = {PW{1'b0}};
    w_sel_wdata = {SRAMC_W{1'b0}};
    w_sel_addr  = {ADRC_W{1'b0}};
    w_sel_wmask = {SRAMC_N{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      w_gnt_idx   = w_gnt_idx | (PW'(k) & {PW{w_grant[k]}});
      w_sel_wdata = w_sel_wdata | ({SRAMC_W{w_grant[k]}} & i_req_wdata[k*SRAMC_W +: SRAMC_W]);
      w_sel_addr  = w_sel_addr | ({ADRC_W{w_grant[k]}} & i_req_addr[k*ADRC_W +: ADRC_W]);
      w_sel_wmask = w_sel_wmask | ({SRAMC_N{w_grant[k]}} & i_req_wmask[k*SRAMC_N +: SRAMC_N]);
    end
  end

  // Credit arithmetic; a return at full credit saturates and flags overflow.
  always_comb begin
    w_credits_nxt = r_credits;
    w_crd_ovf     = 1'b0;
    case ({w_accept, i_credit_ret})
      2'b10: w_credits_nxt = r_credits - CRD_W'(1);
      2'b01: begin
        if (w_crd_full) begin
          w_credits_nxt = r_credits;
          w_crd_ovf     = 1'b1;
        end else begin
          w_credits_nxt = r_credits + CRD_W'(1);
          w_crd_ovf     = 1'b0;
        end
      end
      default: w_credits_nxt = r_credits;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; a flush request while already flushing is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_flush) begin
          w_state_nxt = FLUSH;
        end else if (w_any_valid) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (i_flush) begin
          w_state_nxt = FLUSH;
        end else if (!w_any_valid && w_crd_full) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FLUSH: begin
        if (w_crd_full) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = FLUSH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs; flush_done coincides with the FLUSH -> IDLE transition.
  always_comb begin
    o_flush_done = (r_state == FLUSH) && w_crd_full;
    o_busy       = (r_state != IDLE) || !w_crd_full;
  end

  // Credit counter, sticky overflow flag and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_credits <= CRD_FULL;
      r_err     <= 1'b0;
      r_rr_ptr  <= {PW{1'b0}};
    end else begin
      r_credits <= w_credits_nxt;
      r_err     <= r_err | w_crd_ovf;
      if (w_accept) begin
        r_rr_ptr <= w_gnt_idx;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  // Quantization-side payload: captured on accept, held otherwise.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_q_wdata <= {SRAMC_W{1'b0}};
      r_q_addr  <= {ADRC_W{1'b0}};
      r_q_wmask <= {SRAMC_N{1'b0}};
      r_q_wren  <= 1'b0;
    end else begin
      r_q_wren <= w_accept;
      if (w_accept) begin
        r_q_wdata <= w_sel_wdata;
        r_q_addr  <= w_sel_addr;
        r_q_wmask <= w_sel_wmask;
      end else begin
        r_q_wdata <= r_q_wdata;
        r_q_addr  <= r_q_addr;
        r_q_wmask <= r_q_wmask;
      end
    end
  end

  assign o_req_ready = w_grant;
  assign o_q_wdata   = r_q_wdata;
  assign o_q_addr    = r_q_addr;
  assign o_q_wmask   = r_q_wmask;
  assign o_q_wren    = r_q_wren;
  assign o_credits   = r_credits;
  assign o_err       = r_err;

endmodule

// File: tb/tb_quant_wr_sched.sv
// Directed scoreboard bench for quant_wr_sched: expected payloads are queued at
// accept time and popped when o_q_wren fires.
module tb_quant_wr_sched;
  import quant_sched_pkg::*;

  localparam int NREQ    = 2;
  localparam int W       = QS_SRAMC_W;
  localparam int AW      = QS_ADRC_W;
  localparam int MN      = QS_SRAMC_N;
  localparam int CREDITS = 8;
  localparam int CRD_W   = 4;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ-1:0]      o_req_ready;
  logic [NREQ*W-1:0]    i_req_wdata;
  logic [NREQ*AW-1:0]   i_req_addr;
  logic [NREQ*MN-1:0]   i_req_wmask;
  logic [W-1:0]         o_q_wdata;
  logic [AW-1:0]        o_q_addr;
  logic [0:MN-1]        o_q_wmask;
  logic                 o_q_wren;
  logic                 i_credit_ret;
  logic                 i_flush;
  logic                 o_flush_done;
  logic                 o_busy;
  logic [CRD_W-1:0]     o_credits;
  logic                 o_err;

  int     n_checks = 0;
  int     n_errors = 0;
  int     m_cred   = CREDITS;
  logic   m_err    = 1'b0;
  q_req_t sb[$];

  always #5 clk = ~clk;

  quant_wr_sched #(
    .SRAMC_W (W), .ADRC_W (AW), .SRAMC_N (MN), .NREQ (NREQ), .CREDITS (CREDITS), .CRD_W (CRD_W)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_wdata  (i_req_wdata),
    .i_req_addr   (i_req_addr),
    .i_req_wmask  (i_req_wmask),
    .o_q_wdata    (o_q_wdata),
    .o_q_addr     (o_q_addr),
    .o_q_wmask    (o_q_wmask),
    .o_q_wren     (o_q_wren),
    .i_credit_ret (i_credit_ret),
    .i_flush      (i_flush),
    .o_flush_done (o_flush_done),
    .o_busy       (o_busy),
    .o_credits    (o_credits),
    .o_err        (o_err)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [AW-1:0] a, input logic [MN-1:0] m);
    i_req_valid[k]          = v;
    i_req_addr[k*AW +: AW]  = a;
    i_req_wmask[k*MN +: MN] = m;
    for (int j = 0; j < W / 32; j++) begin
      i_req_wdata[k*W + j*32 +: 32] = $urandom();
    end
  endtask

  // One clock: check combinational outputs at the negedge, queue the expected
  // write, then check the registered outputs just after the posedge.
  task automatic cyc(input logic [1:0] exp_rdy, input logic exp_fd);
    q_req_t e;
    int     g;
    logic   acc;
    @(negedge clk);
    check("ready", 256'(o_req_ready), 256'(exp_rdy));
    check("flush_done", 256'(o_flush_done), 256'(exp_fd));
    acc = |exp_rdy;
    if (acc) begin
      g       = exp_rdy[1] ? 1 : 0;
      e.wdata = i_req_wdata[g*W +: W];
      e.addr  = i_req_addr[g*AW +: AW];
      e.wmask = i_req_wmask[g*MN +: MN];
      sb.push_back(e);
    end
    if (acc && !i_credit_ret) begin
      m_cred = m_cred - 1;
    end else if (!acc && i_credit_ret) begin
      if (m_cred == CREDITS) m_err = 1'b1;
      else m_cred = m_cred + 1;
    end
    @(posedge clk);
    #1;
    check("wren", 256'(o_q_wren), 256'(sb.size() != 0));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("q_addr", 256'(o_q_addr), 256'(e.addr));
      check("q_wmask", 256'(o_q_wmask), 256'(e.wmask));
      for (int c = 0; c < W / 256; c++) begin
        check($sformatf("q_wdata[%0d]", c), o_q_wdata[c*256 +: 256], e.wdata[c*256 +: 256]);
      end
    end
    check("credits", 256'(o_credits), 256'(m_cred));
    check("err", 256'(o_err), 256'(m_err));
  endtask

  initial begin
    rstn         = 1'b0;
    i_req_valid  = '0;
    i_req_wdata  = '0;
    i_req_addr   = '0;
    i_req_wmask  = '0;
    i_credit_ret = 1'b0;
    i_flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 256'(o_req_ready), 256'(2'b00));
    check("rst_wren", 256'(o_q_wren), 256'(1'b0));
    check("rst_addr", 256'(o_q_addr), 256'(11'h000));
    check("rst_wmask", 256'(o_q_wmask), 256'(32'h0));
    check("rst_credits", 256'(o_credits), 256'(4'd8));
    check("rst_err", 256'(o_err), 256'(1'b0));
    check("rst_busy", 256'(o_busy), 256'(1'b0));
    rstn = 1'b1;

    // Single write from requester 0, ready in the same cycle.
    set_req(0, 1'b1, 11'h010, 32'hFFFF_FFFF);
    cyc(2'b01, 1'b0);
    check("t1_addr", 256'(o_q_addr), 256'(11'h010));
    check("t1_credits", 256'(o_credits), 256'(4'd7));
    set_req(0, 1'b0, 11'h055, 32'h0);
    cyc(2'b00, 1'b0);
    check("t1_hold_addr", 256'(o_q_addr), 256'(11'h010));
    i_credit_ret = 1'b1;
    cyc(2'b00, 1'b0);
    i_credit_ret = 1'b0;

    // Both requesters valid: grants alternate starting with requester 1.
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, AW'(11'h020 + i), $urandom());
      set_req(1, 1'b1, AW'(11'h040 + i), $urandom());
      cyc((i % 2 == 0) ? 2'b10 : 2'b01, 1'b0);
    end
    check("t2_credits", 256'(o_credits), 256'(4'd2));
    i_req_valid  = 2'b00;
    i_credit_ret = 1'b1;
    for (int i = 0; i < 6; i++) cyc(2'b00, 1'b0);
    i_credit_ret = 1'b0;

    // Exhaust credits; the 9th request waits for a return.
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, AW'(11'h100 + i), $urandom());
      cyc(2'b01, 1'b0);
    end
    set_req(0, 1'b1, 11'h108, 32'hA5A5_5A5A);
    cyc(2'b00, 1'b0);
    check("t3_stall_credits", 256'(o_credits), 256'(4'd0));
    i_credit_ret = 1'b1;
    cyc(2'b00, 1'b0);
    i_credit_ret = 1'b0;
    cyc(2'b01, 1'b0);
    check("t3_credits_after", 256'(o_credits), 256'(4'd0));
    i_req_valid  = 2'b00;
    i_credit_ret = 1'b1;
    for (int i = 0; i < 5; i++) cyc(2'b00, 1'b0);

    // Accept and return together at credits=5.
    set_req(1, 1'b1, 11'h200, $urandom());
    cyc(2'b10, 1'b0);
    check("t4_credits", 256'(o_credits), 256'(4'd5));
    i_req_valid = 2'b00;
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0);
    i_credit_ret = 1'b0;

    // Three writes in flight, then flush; a request during flush is held off.
    for (int i = 0; i < 3; i++) begin
      set_req(0, 1'b1, AW'(11'h300 + i), $urandom());
      cyc(2'b01, 1'b0);
    end
    set_req(0, 1'b0, 11'h000, 32'h0);
    set_req(1, 1'b1, 11'h3F0, $urandom());
    i_flush = 1'b1;
    cyc(2'b00, 1'b0);
    i_flush = 1'b0;
    check("t5_busy_flush", 256'(o_busy), 256'(1'b1));
    i_credit_ret = 1'b1;
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0);
    i_credit_ret = 1'b0;
    cyc(2'b00, 1'b1);
    i_req_valid = 2'b00;
    cyc(2'b00, 1'b0);
    check("t5_busy_idle", 256'(o_busy), 256'(1'b0));

    // Credit return at full count sets the sticky error.
    i_credit_ret = 1'b1;
    cyc(2'b00, 1'b0);
    i_credit_ret = 1'b0;
    cyc(2'b00, 1'b0);
    check("t6_err", 256'(o_err), 256'(1'b1));
    check("t6_credits", 256'(o_credits), 256'(4'd8));

    // Asynchronous reset in the middle of RUN.
    set_req(0, 1'b1, 11'h077, $urandom());
    cyc(2'b01, 1'b0);
    rstn = 1'b0;
    #1;
    check("arst_ready", 256'(o_req_ready), 256'(2'b00));
    check("arst_wren", 256'(o_q_wren), 256'(1'b0));
    check("arst_addr", 256'(o_q_addr), 256'(11'h000));
    check("arst_credits", 256'(o_credits), 256'(4'd8));
    check("arst_err", 256'(o_err), 256'(1'b0));
    check("arst_busy", 256'(o_busy), 256'(1'b0));
    sb.delete();
    m_cred = CREDITS;
    m_err  = 1'b0;
    #1;
    rstn = 1'b1;
    cyc(2'b01, 1'b0);
    i_req_valid = 2'b00;
    cyc(2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
